fifo_reader: RTL and testbench

//  Read-side controller for the team's synchronous FIFO (registered read port, 1-cycle read latency).

---
 rtl/fifo_reader_pkg.sv | 11 +
 rtl/fifo_reader_buf.sv | 63 ++++++
 rtl/fifo_reader.sv | 67 ++++++
 tb/tb_fifo_reader.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_reader_pkg.sv
// Shared defaults for the FIFO read-side controller and its buffer.
package fifo_reader_pkg;
  localparam int DEF_WIDTH     = 8;
  localparam int DEF_BUF_DEPTH = 4;
  localparam int DEF_CNT_W     = 16;

  // Occupancy must count 0..depth inclusive.
  function automatic int occ_width(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/fifo_reader_buf.sv
// Circular skid buffer: push at wr_ptr, pop at rd_ptr, head is the stored word at rd_ptr.
module fifo_reader_buf
  import fifo_reader_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_BUF_DEPTH,
  localparam int PW = $clog2(DEPTH),
  localparam int OW = occ_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [OW-1:0]    occ
);
  localparam logic [OW-1:0] FULL = OW'(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [PW-1:0]               wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]               rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]               occ_q, occ_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    // Simultaneous push and pop leave occupancy unchanged.
    if (push && !pop) begin
      occ_d = occ_q + OW'(1);
    end else if (pop && !push) begin
      occ_d = occ_q - OW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      assert (!(push && !pop && occ_q == FULL));
      assert (!(pop && occ_q == '0));
    end
  end

  assign head = mem_q[rd_ptr_q];
  assign occ  = occ_q;
endmodule

// File: rtl/fifo_reader.sv
// Consumer end of the synchronous FIFO: issues reads against reserved buffer space and
// streams captured words downstream on m_valid/m_ready.
module fifo_reader
  import fifo_reader_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int BUF_DEPTH = DEF_BUF_DEPTH,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             empty,
  output logic             re,
  input  logic [WIDTH-1:0] data_in,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [CNT_W-1:0] rd_count
);
  // Handshake: a word transfers on any cycle where m_valid and m_ready are both 1;
  // m_valid never depends on m_ready, and a stalled word holds m_data until taken.
  localparam int OW = occ_width(BUF_DEPTH);
  localparam logic [OW:0] DEPTH_L = (OW+1)'(BUF_DEPTH);

  logic [OW-1:0]    occ;
  logic [OW:0]      reserved;
  logic             pop;
  logic             rd_pend_q, rd_pend_d;
  logic [CNT_W-1:0] rd_count_q, rd_count_d;

  // A word in flight already owns an entry, so it counts against free space.
  always_comb begin
    reserved   = {1'b0, occ} + {{OW{1'b0}}, rd_pend_q};
    re         = ~rst & en & ~empty & (reserved < DEPTH_L);
    pop        = m_valid & m_ready;
    rd_pend_d  = re;
    rd_count_d = pop ? rd_count_q + CNT_W'(1) : rd_count_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pend_q  <= 1'b0;
      rd_count_q <= '0;
    end else begin
      rd_pend_q  <= rd_pend_d;
      rd_count_q <= rd_count_d;
      assert (!(re && empty));
    end
  end

  fifo_reader_buf #(
    .WIDTH (WIDTH),
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (rd_pend_q),
    .push_data (data_in),
    .pop       (pop),
    .head      (m_data),
    .occ       (occ)
  );

  assign m_valid  = (occ != '0);
  assign rd_count = rd_count_q;
endmodule

// File: tb/tb_fifo_reader.sv
// Bench for fifo_reader with a queue-based FIFO in front and a word-count reference model.
module tb_fifo_reader;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic             empty = 1'b1;
  logic             re;
  logic [WIDTH-1:0] data_in = '0;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic [WIDTH-1:0] m_data;
  logic [CNT_W-1:0] rd_count;

  fifo_reader #(.WIDTH(WIDTH), .BUF_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .empty    (empty),
    .re       (re),
    .data_in  (data_in),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .rd_count (rd_count)
  );

  always #10 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [WIDTH-1:0] fifo_q[$];
  logic [WIDTH-1:0] exp_q[$];
  int cap_cnt = 0;
  int delivered = 0;
  int pend_m = 0;
  int popped = 0;
  int cycle = 0;
  int re_pulses = 0;
  int first_re_cyc = -1;
  int first_val_cyc = -1;
  int last_pop_cyc = -1;
  logic stall_prev = 1'b0;
  logic [WIDTH-1:0] prev_data = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    miscompares++;
    $error("FAIL timeout_%s observed=expired expected=event", tag);
  endtask

  task automatic push_word(input logic [WIDTH-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
    empty = 1'b0;
  endtask

  // One clock: check at negedge against the model, then apply FIFO effects after posedge.
  task automatic tick();
    logic exp_re;
    logic re_s;
    int   held;
    @(negedge clk);
    held   = cap_cnt - delivered;
    exp_re = !rst && en && !empty && (held + pend_m < DEPTH);
    chk("re", re, exp_re);
    chk("m_valid", m_valid, held != 0);
    chk("rd_count", rd_count, delivered & 32'hFFFF);
    if (stall_prev && !rst) begin
      chk("hold_data", m_data, prev_data);
    end
    if (m_valid && m_ready) begin
      if (first_val_cyc < 0) first_val_cyc = cycle;
      last_pop_cyc = cycle;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $error("FAIL spurious_word observed=%0h expected=none", m_data);
      end else begin
        chk("m_data", m_data, exp_q.pop_front());
      end
      delivered++;
    end
    stall_prev = m_valid && !m_ready;
    prev_data  = m_data;
    re_s       = re;
    if (re_s) begin
      re_pulses++;
      if (first_re_cyc < 0) first_re_cyc = cycle;
    end
    @(posedge clk);
    #1;
    if (rst) begin
      fifo_q.delete();
      exp_q.delete();
      cap_cnt = 0; delivered = 0; pend_m = 0; popped = 0;
      stall_prev = 1'b0;
    end else begin
      cap_cnt += pend_m;
      pend_m = re_s ? 1 : 0;
      if (re_s && fifo_q.size() > 0) begin
        data_in = fifo_q.pop_front();
        popped++;
      end else begin
        data_in = WIDTH'($urandom);
      end
    end
    empty = (fifo_q.size() == 0);
    cycle++;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || cap_cnt != delivered || pend_m != 0) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) timeout(tag);
  endtask

  initial begin
    int base;
    int n;
    logic [WIDTH-1:0] first_w;

    // 1: reset, then idle on an empty FIFO
    rst = 1'b1; en = 1'b1; m_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("reset_m_data", m_data, 8'h00);
    chk("reset_m_valid", m_valid, 1'b0);
    chk("reset_rd_count", rd_count, 0);
    for (int i = 0; i < 3; i++) tick();
    chk("idle_no_re", re_pulses, 0);

    // 2: five words, downstream always ready
    m_ready = 1'b1;
    first_re_cyc = -1; first_val_cyc = -1;
    for (int i = 1; i <= 5; i++) push_word(WIDTH'(i));
    drain("t2");
    chk("t2_latency", first_val_cyc - first_re_cyc, 2);
    chk("t2_back_to_back", last_pop_cyc - first_val_cyc, 4);
    chk("t2_rd_count", rd_count, 5);
    tick();
    chk("t2_empty_no_re", re, 1'b0);

    // 3: ten words with downstream stalled
    m_ready = 1'b0;
    base = re_pulses;
    for (int i = 0; i < 10; i++) push_word(WIDTH'($urandom));
    first_w = exp_q[0];
    for (int i = 0; i < 10; i++) tick();
    chk("t3_re_pulses", re_pulses - base, DEPTH);
    chk("t3_valid", m_valid, 1'b1);
    chk("t3_head", m_data, first_w);
    m_ready = 1'b1;
    drain("t3");
    chk("t3_rd_count", rd_count, 15);

    // 4: sixteen words with ready toggling
    for (int i = 0; i < 16; i++) push_word(WIDTH'($urandom));
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      m_ready = (n % 2 == 0);
      tick();
      n++;
    end
    if (n >= 200) timeout("t4");
    m_ready = 1'b1;
    drain("t4_tail");
    chk("t4_rd_count", rd_count, 31);

    // 5: drop en right after a read issues
    for (int i = 0; i < 6; i++) push_word(WIDTH'($urandom));
    n = 0;
    base = re_pulses;
    while (re_pulses == base && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) timeout("t5_re");
    en = 1'b0;
    base = re_pulses;
    n = fifo_q.size();
    for (int i = 0; i < 6; i++) tick();
    chk("t5_no_re", re_pulses - base, 0);
    chk("t5_fifo_frozen", fifo_q.size(), n);
    chk("t5_inflight_delivered", rd_count, popped);
    en = 1'b1;
    drain("t5");

    // 6: reset with three buffered words and one in flight
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) push_word(WIDTH'($urandom));
    n = 0;
    while (!((cap_cnt - delivered) == 3 && pend_m == 1) && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) timeout("t6_fill");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_valid_after_rst", m_valid, 1'b0);
    chk("t6_count_after_rst", rd_count, 0);
    m_ready = 1'b1;
    tick(); tick();
    for (int i = 0; i < 3; i++) push_word(WIDTH'($urandom));
    drain("t6");
    chk("t6_rd_count", rd_count, 3);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      en = ($urandom_range(0, 3) != 0);
      m_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 1) == 1) push_word(WIDTH'($urandom));
      tick();
    end
    en = 1'b1;
    m_ready = 1'b1;
    drain("random");
    chk("random_rd_count", rd_count, delivered & 32'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
